decode_stage_hz: RTL and testbench
==================================

# decode_stage_hz

Parametrised decode stage for the pipelined processor. It decodes the 16-bit instruction from fetch, reads an internal register file with write-back bypass, and drives the ID/EX pipeline register. Unlike the plain decode stage, it also detects load-use hazards and inserts bubbles, honours external stall and flush, carries a valid bit, and counts hazard bubbles. It sits between fetch (IF/ID) and execute; write-back feeds its register-file write port.

## Interface
- DATA_W, 16: register/data width (≥ 8); immediate sign-extended to DATA_W
- N_REGS, 8: register count (2..8); addresses are 3 bits; writes/reads to index ≥ N_REGS are ignored/return 0
- CNT_W, 8: width of saturating hazard-bubble counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instruction  in  16  instruction from IF/ID
- in_valid  in  1  instruction is real (0 = treat as NOP)
- stall_in  in  1  freeze ID/EX register (downstream hold)
- flush  in  1  discard current instruction, load bubble
- wb_we  in  1  register-file write enable from write-back
- wb_addr  in  3  write-back destination
- wb_data  in  DATA_W  write-back data
- hazard_stall  out  1  combinational; fetch must hold PC and IF/ID
- valid_r  out  1  ID/EX entry valid
- ALUOp_r  out  2; carrySelect_r  out  2
- WB_ALUtoReg_r, RegWrite_r, MemRead_r, MemWrite_r, use_imm_r  out  1 each
- read_data1_r, read_data2_r  out  DATA_W  R[rd], R[rs2]
- imm_r  out  DATA_W  sign-extended instruction[6:0]
- rd_addr_r, rs2_addr_r  out  3  for forwarding and write-back
- bubble_count  out  CNT_W  hazard bubbles since reset, saturating

## Operation
- Fields: op=[15:13], rd=[12:10], rs2=[9:7], imm=[6:0].
- 000 NOP: all controls 0.
- 001 ALU: ALUOp=[1:0], RegWrite=1, WB_ALUtoReg=1; reads rd, rs2.
- 010 ADDI: ALUOp=00, use_imm=1, RegWrite=1, WB_ALUtoReg=1; reads rs2.
- 011 LDM: ALUOp=00, use_imm=1, MemRead=1, RegWrite=1, WB_ALUtoReg=0; reads rs2.
- 100 STD: ALUOp=00, use_imm=1, MemWrite=1; reads rd (data), rs2 (base).
- 101 SETC: carrySelect=01. 110 CLRC: carrySelect=10. 111: NOP.
- in_valid=0 decodes as NOP with valid=0.
- Register file: N_REGS × DATA_W, cleared by rst. Written on clk edge when wb_we, independent of stall/flush.
- Reads are combinational with bypass: if wb_we and wb_addr matches the read address, wb_data is returned.
- Load-use: hazard = valid_r & MemRead_r & in_valid & (rd_addr_r equals a register the current op reads).
- hazard_stall = hazard & ~flush & ~stall_in.
- Per-edge priority, highest first:
  - flush: load bubble (valid and all controls 0; data/addr fields don't-care, driven 0).
  - stall_in: hold ID/EX unchanged.
  - hazard: load bubble and increment bubble_count (saturate at 2^CNT_W−1).
  - else: load the decoded instruction.

## Timing
- Reset: every _r output, valid_r and bubble_count are 0; all registers are 0; hazard_stall is 0 because valid_r=0. Reset is asynchronous and also applies mid-operation.
- Latency: one cycle from instruction to ID/EX outputs.
- Hazard insertion costs exactly one bubble. Next cycle the LDM has left ID/EX (valid_r on the bubble is 0), so the held instruction proceeds.
- stall_in held N cycles: outputs are constant N cycles, no bubble is counted, and hazard_stall is forced low.
- Simultaneous write-back and read of the same register in one cycle: new data is captured (bypass).
- flush together with hazard: flush wins, no count.
- Register 0 is writable (no hard-wired zero).

## Test plan
- Reset mid-run: rst pulse → all outputs 0, R0..R7 read 0 next instruction.
- Write R3=0x1234 via wb, same cycle decode ALU rd=3 → read_data1_r=0x1234 next edge (bypass).
- LDM rd=2 then ADDI rs2=2 → hazard_stall=1 for one cycle, bubble (valid_r=0), then ADDI with rs2_addr_r=2, bubble_count=1.
- LDM rd=2 then ADDI rs2=5 → no stall, bubble_count stays 0.
- LDM rd=4 then STD rd=4 with flush=1 → bubble loaded, hazard_stall=0, count unchanged.
- stall_in=1 for 3 cycles during ALU op → ID/EX constant; CNT_W=2 with 5 forced hazards → bubble_count=3 (saturated).

Source files
------------

// File: rtl/decode_stage_hz_if.sv
// Fetch/write-back/ID-EX signal bundle for decode_stage_hz.
// The master side is fetch plus write-back; the slave side is the decode stage.
interface decode_stage_hz_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic [15:0]       instruction;
  logic              in_valid;
  logic              stall_in;
  logic              flush;
  logic              wb_we;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              hazard_stall;
  logic              valid_r;
  logic [1:0]        ALUOp_r;
  logic [1:0]        carrySelect_r;
  logic              WB_ALUtoReg_r;
  logic              RegWrite_r;
  logic              MemRead_r;
  logic              MemWrite_r;
  logic              use_imm_r;
  logic [DATA_W-1:0] read_data1_r;
  logic [DATA_W-1:0] read_data2_r;
  logic [DATA_W-1:0] imm_r;
  logic [2:0]        rd_addr_r;
  logic [2:0]        rs2_addr_r;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output instruction, in_valid, stall_in, flush, wb_we, wb_addr, wb_data,
    input  hazard_stall, valid_r, ALUOp_r, carrySelect_r, WB_ALUtoReg_r, RegWrite_r,
           MemRead_r, MemWrite_r, use_imm_r, read_data1_r, read_data2_r, imm_r,
           rd_addr_r, rs2_addr_r, bubble_count
  );

  modport slave (
    input  instruction, in_valid, stall_in, flush, wb_we, wb_addr, wb_data,
    output hazard_stall, valid_r, ALUOp_r, carrySelect_r, WB_ALUtoReg_r, RegWrite_r,
           MemRead_r, MemWrite_r, use_imm_r, read_data1_r, read_data2_r, imm_r,
           rd_addr_r, rs2_addr_r, bubble_count
  );
endinterface

// File: rtl/decode_stage_hz.sv
// Decode stage with bypassed register file, load-use bubble insertion,
// stall/flush handling and a saturating hazard-bubble counter.
module decode_stage_hz #(
  parameter int DATA_W = 16,
  parameter int N_REGS = 8,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  decode_stage_hz_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ALU  = 3'b001,
    OP_ADDI = 3'b010,
    OP_LDM  = 3'b011,
    OP_STD  = 3'b100,
    OP_SETC = 3'b101,
    OP_CLRC = 3'b110,
    OP_RSV  = 3'b111
  } op_e;

  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic [1:0]        carry_sel;
    logic              wb_alu;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              use_imm;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [2:0]        rd;
    logic [2:0]        rs2;
  } idex_t;

  localparam logic [3:0] NREGS4 = 4'(N_REGS);

  op_e               op;
  logic [2:0]        rd;
  logic [2:0]        rs2;
  logic [DATA_W-1:0] rf [N_REGS];
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              reads_rd;
  logic              reads_rs2;
  logic              hazard;
  idex_t             dec;
  idex_t             idex;
  logic [CNT_W-1:0]  cnt;

  assign op  = op_e'(bus.instruction[15:13]);
  assign rd  = bus.instruction[12:10];
  assign rs2 = bus.instruction[9:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf <= '{default: '0};
    end else if (bus.wb_we && ({1'b0, bus.wb_addr} < NREGS4)) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Out-of-range addresses read 0 even when write-back targets them.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if ({1'b0, rd} < NREGS4)
      rdata1 = (bus.wb_we && bus.wb_addr == rd) ? bus.wb_data : rf[rd];
    if ({1'b0, rs2} < NREGS4)
      rdata2 = (bus.wb_we && bus.wb_addr == rs2) ? bus.wb_data : rf[rs2];
  end

  always_comb begin
    dec       = '0;
    reads_rd  = 1'b0;
    reads_rs2 = 1'b0;
    dec.valid = bus.in_valid;
    dec.rd1   = rdata1;
    dec.rd2   = rdata2;
    dec.imm   = {{(DATA_W-7){bus.instruction[6]}}, bus.instruction[6:0]};
    dec.rd    = rd;
    dec.rs2   = rs2;
    if (bus.in_valid) begin
      case (op)
        OP_ALU: begin
          dec.alu_op    = bus.instruction[1:0];
          dec.reg_write = 1'b1;
          dec.wb_alu    = 1'b1;
          reads_rd      = 1'b1;
          reads_rs2     = 1'b1;
        end
        OP_ADDI: begin
          dec.use_imm   = 1'b1;
          dec.reg_write = 1'b1;
          dec.wb_alu    = 1'b1;
          reads_rs2     = 1'b1;
        end
        OP_LDM: begin
          dec.use_imm   = 1'b1;
          dec.mem_read  = 1'b1;
          dec.reg_write = 1'b1;
          reads_rs2     = 1'b1;
        end
        OP_STD: begin
          dec.use_imm   = 1'b1;
          dec.mem_write = 1'b1;
          reads_rd      = 1'b1;
          reads_rs2     = 1'b1;
        end
        OP_SETC: dec.carry_sel = 2'b01;
        OP_CLRC: dec.carry_sel = 2'b10;
        default: ;
      endcase
    end
  end

  assign hazard = idex.valid & idex.mem_read & bus.in_valid &
                  ((reads_rd & (rd == idex.rd)) | (reads_rs2 & (rs2 == idex.rd)));
  assign bus.hazard_stall = hazard & ~bus.flush & ~bus.stall_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      idex <= '0;
    end else if (bus.stall_in) begin
      idex <= idex;
    end else if (hazard) begin
      idex <= '0;
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
    end else begin
      idex <= dec;
    end
  end

  assign bus.valid_r       = idex.valid;
  assign bus.ALUOp_r       = idex.alu_op;
  assign bus.carrySelect_r = idex.carry_sel;
  assign bus.WB_ALUtoReg_r = idex.wb_alu;
  assign bus.RegWrite_r    = idex.reg_write;
  assign bus.MemRead_r     = idex.mem_read;
  assign bus.MemWrite_r    = idex.mem_write;
  assign bus.use_imm_r     = idex.use_imm;
  assign bus.read_data1_r  = idex.rd1;
  assign bus.read_data2_r  = idex.rd2;
  assign bus.imm_r         = idex.imm;
  assign bus.rd_addr_r     = idex.rd;
  assign bus.rs2_addr_r    = idex.rs2;
  assign bus.bubble_count  = cnt;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Self-checking bench for decode_stage_hz: directed scenarios plus randomized
// traffic against an instruction-level reference model.
module tb_decode_stage_hz;
  localparam int DATA_W = 16;
  localparam int N_REGS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_hz_if #(.DATA_W(DATA_W), .CNT_W(8)) bus ();
  decode_stage_hz_if #(.DATA_W(DATA_W), .CNT_W(2)) bus2 ();

  decode_stage_hz #(.DATA_W(DATA_W), .N_REGS(N_REGS), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  decode_stage_hz #(.DATA_W(DATA_W), .N_REGS(N_REGS), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.instruction = bus.instruction;
  assign bus2.in_valid    = bus.in_valid;
  assign bus2.stall_in    = bus.stall_in;
  assign bus2.flush       = bus.flush;
  assign bus2.wb_we       = bus.wb_we;
  assign bus2.wb_addr     = bus.wb_addr;
  assign bus2.wb_data     = bus.wb_data;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic [1:0]  carry;
    logic        wbalu, regw, memr, memw, useimm;
    logic [15:0] rd1, rd2, imm;
    logic [2:0]  rd, rs2;
  } ent_t;

  ent_t        m;
  int          m_cnt, m_cnt2;
  logic [15:0] m_rf [8];
  int          errors = 0;
  int          checks = 0;

  // ---------------- reference model ----------------
  function automatic logic [15:0] mread(input logic [2:0] a);
    if (int'(a) >= N_REGS) return 16'h0;
    if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
    return m_rf[a];
  endfunction

  function automatic bit uses_rd(input logic [2:0] op);
    return op == 3'd1 || op == 3'd4;
  endfunction

  function automatic bit uses_rs2(input logic [2:0] op);
    return op >= 3'd1 && op <= 3'd4;
  endfunction

  function automatic ent_t mdecode();
    ent_t e;
    logic [15:0] ins;
    ins = bus.instruction;
    e = '0;
    e.valid = bus.in_valid;
    e.rd1 = mread(ins[12:10]);
    e.rd2 = mread(ins[9:7]);
    e.imm = {{9{ins[6]}}, ins[6:0]};
    e.rd  = ins[12:10];
    e.rs2 = ins[9:7];
    if (bus.in_valid) begin
      case (ins[15:13])
        3'd1: begin e.aluop = ins[1:0]; e.regw = 1; e.wbalu = 1; end
        3'd2: begin e.useimm = 1; e.regw = 1; e.wbalu = 1; end
        3'd3: begin e.useimm = 1; e.memr = 1; e.regw = 1; end
        3'd4: begin e.useimm = 1; e.memw = 1; end
        3'd5: e.carry = 2'd1;
        3'd6: e.carry = 2'd2;
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic bit mhz();
    logic [2:0] op, rd, rs2;
    op  = bus.instruction[15:13];
    rd  = bus.instruction[12:10];
    rs2 = bus.instruction[9:7];
    return m.valid && m.memr && bus.in_valid &&
           ((uses_rd(op) && rd == m.rd) || (uses_rs2(op) && rs2 == m.rd));
  endfunction

  function automatic logic exp_hstall();
    return mhz() && !bus.flush && !bus.stall_in;
  endfunction

  function automatic ent_t actual();
    ent_t a;
    a.valid = bus.valid_r;       a.aluop = bus.ALUOp_r;     a.carry = bus.carrySelect_r;
    a.wbalu = bus.WB_ALUtoReg_r; a.regw  = bus.RegWrite_r;  a.memr  = bus.MemRead_r;
    a.memw  = bus.MemWrite_r;    a.useimm = bus.use_imm_r;
    a.rd1 = bus.read_data1_r;    a.rd2 = bus.read_data2_r;  a.imm = bus.imm_r;
    a.rd  = bus.rd_addr_r;       a.rs2 = bus.rs2_addr_r;
    return a;
  endfunction

  task automatic model_reset();
    m = '0;
    m_cnt = 0;
    m_cnt2 = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
  endtask

  task automatic drive(input logic [15:0] ins, input logic iv, input logic st, input logic fl,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd);
    bus.instruction = ins; bus.in_valid = iv; bus.stall_in = st; bus.flush = fl;
    bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd;
    #1;
  endtask

  // Advance one clock edge, updating the model from the inputs that edge sees.
  task automatic tick();
    ent_t nxt;
    bit   hz, we_ok;
    logic [2:0]  wa;
    logic [15:0] wd;
    nxt = m;
    hz  = mhz();
    if (bus.flush) nxt = '0;
    else if (bus.stall_in) nxt = m;
    else if (hz) begin
      nxt = '0;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else nxt = mdecode();
    we_ok = bus.wb_we && int'(bus.wb_addr) < N_REGS;
    wa = bus.wb_addr;
    wd = bus.wb_data;
    @(posedge clk);
    #1;
    m = nxt;
    if (we_ok) m_rf[wa] = wd;
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs2, input int imm);
    return {3'(op), 3'(rd), 3'(rs2), 7'(imm)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(16'h0, 0, 0, 0, 0, 3'd0, 16'h0);
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({actual(), bus.bubble_count, bus.hazard_stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {actual(), bus.bubble_count, bus.hazard_stall});
    end
    checks++;
    if (bus2.bubble_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_sat_count got %0d want 0", bus2.bubble_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    drive(mk(1, 3, 3, 2), 1, 0, 0, 1, 3'd3, 16'h1234);
    checks++;
    if (bus.hazard_stall !== 1'b0) begin
      errors++; $display("FAIL bypass_hz got %b want 0", bus.hazard_stall);
    end
    tick();
    checks++;
    if (bus.read_data1_r !== 16'h1234 || bus.read_data2_r !== 16'h1234 || bus.valid_r !== 1'b1) begin
      errors++;
      $display("FAIL bypass_data got %h/%h want 1234/1234", bus.read_data1_r, bus.read_data2_r);
    end
    checks++;
    if (actual() !== m) begin
      errors++; $display("FAIL bypass_entry got %h want %h", actual(), m);
    end
  endtask

  task automatic test_load_use();
    int c0;
    c0 = m_cnt;
    drive(mk(3, 2, 0, 5), 1, 0, 0, 0, 3'd0, 16'h0);
    tick();
    drive(mk(2, 6, 2, 7'h7f), 1, 0, 0, 0, 3'd0, 16'h0);
    checks++;
    if (bus.hazard_stall !== 1'b1) begin
      errors++; $display("FAIL loaduse_hz got %b want 1", bus.hazard_stall);
    end
    tick();
    checks++;
    if (bus.valid_r !== 1'b0 || actual() !== m) begin
      errors++; $display("FAIL loaduse_bubble got %h want %h", actual(), m);
    end
    drive(mk(2, 6, 2, 7'h7f), 1, 0, 0, 0, 3'd0, 16'h0);
    checks++;
    if (bus.hazard_stall !== 1'b0) begin
      errors++; $display("FAIL loaduse_release got %b want 0", bus.hazard_stall);
    end
    tick();
    checks++;
    if (bus.valid_r !== 1'b1 || bus.rs2_addr_r !== 3'd2 || bus.imm_r !== 16'hffff ||
        int'(bus.bubble_count) !== c0 + 1) begin
      errors++;
      $display("FAIL loaduse_issue got v=%b rs2=%0d imm=%h cnt=%0d want v=1 rs2=2 imm=ffff cnt=%0d",
               bus.valid_r, bus.rs2_addr_r, bus.imm_r, bus.bubble_count, c0 + 1);
    end
  endtask

  task automatic test_no_hazard();
    int c0;
    c0 = m_cnt;
    drive(mk(3, 2, 0, 1), 1, 0, 0, 0, 3'd0, 16'h0);
    tick();
    drive(mk(2, 1, 5, 3), 1, 0, 0, 0, 3'd0, 16'h0);
    checks++;
    if (bus.hazard_stall !== 1'b0) begin
      errors++; $display("FAIL nohz_hz got %b want 0", bus.hazard_stall);
    end
    tick();
    checks++;
    if (bus.valid_r !== 1'b1 || bus.rs2_addr_r !== 3'd5 || int'(bus.bubble_count) !== c0) begin
      errors++;
      $display("FAIL nohz_issue got v=%b rs2=%0d cnt=%0d want v=1 rs2=5 cnt=%0d",
               bus.valid_r, bus.rs2_addr_r, bus.bubble_count, c0);
    end
  endtask

  task automatic test_flush_hazard();
    int c0;
    c0 = m_cnt;
    drive(mk(3, 4, 1, 0), 1, 0, 0, 0, 3'd0, 16'h0);
    tick();
    drive(mk(4, 4, 0, 2), 1, 0, 1, 0, 3'd0, 16'h0);
    checks++;
    if (bus.hazard_stall !== 1'b0) begin
      errors++; $display("FAIL flush_hz got %b want 0", bus.hazard_stall);
    end
    tick();
    checks++;
    if ({actual(), bus.bubble_count} !== {ent_t'('0), 8'(c0)}) begin
      errors++; $display("FAIL flush_bubble got %h want %h", {actual(), bus.bubble_count}, {ent_t'('0), 8'(c0)});
    end
  endtask

  task automatic test_stall();
    ent_t snap;
    logic [7:0] csnap;
    drive(mk(1, 1, 2, 3), 1, 0, 0, 0, 3'd0, 16'h0);
    tick();
    snap = actual();
    csnap = bus.bubble_count;
    for (int i = 0; i < 3; i++) begin
      drive(mk(3, i, i + 1, i), 1, 1, 0, 1, 3'(i + 1), 16'(16'h0a00 + i));
      tick();
      checks++;
      if ({actual(), bus.bubble_count} !== {snap, csnap} || actual() !== m) begin
        errors++; $display("FAIL stall_hold cycle %0d got %h want %h", i, actual(), snap);
      end
    end
    // Hazard present while stalled: never requested, never counted.
    drive(mk(3, 5, 0, 0), 1, 0, 0, 0, 3'd0, 16'h0);
    tick();
    csnap = bus.bubble_count;
    for (int i = 0; i < 2; i++) begin
      drive(mk(2, 0, 5, 1), 1, 1, 0, 0, 3'd0, 16'h0);
      checks++;
      if (bus.hazard_stall !== 1'b0) begin
        errors++; $display("FAIL stall_hz_forced got %b want 0", bus.hazard_stall);
      end
      tick();
      checks++;
      if (bus.bubble_count !== csnap || bus.MemRead_r !== 1'b1) begin
        errors++; $display("FAIL stall_nocount got cnt=%0d mr=%b want cnt=%0d mr=1",
                           bus.bubble_count, bus.MemRead_r, csnap);
      end
    end
  endtask

  task automatic test_saturation();
    int c0;
    c0 = m_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(mk(3, 1, 0, i), 1, 0, 0, 0, 3'd0, 16'h0);
      tick();
      drive(mk(2, 3, 1, 0), 1, 0, 0, 0, 3'd0, 16'h0);
      tick();
      drive(mk(2, 3, 1, 0), 1, 0, 0, 0, 3'd0, 16'h0);
      tick();
    end
    checks++;
    if (bus2.bubble_count !== 2'd3) begin
      errors++; $display("FAIL sat_count got %0d want 3", bus2.bubble_count);
    end
    checks++;
    if (int'(bus.bubble_count) !== c0 + 5) begin
      errors++; $display("FAIL sat_main_count got %0d want %0d", bus.bubble_count, c0 + 5);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      drive(mk(3, i, i, 0), 1, 0, 0, 1, 3'(i), 16'(16'h1111 * (i + 1)));
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({actual(), bus.bubble_count, bus.hazard_stall} !== '0) begin
      errors++; $display("FAIL midreset_outputs got %h want 0", {actual(), bus.bubble_count, bus.hazard_stall});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(mk(1, i, i + 4, 0), 1, 0, 0, 0, 3'd0, 16'h0);
      tick();
      checks++;
      if (bus.read_data1_r !== 16'h0 || bus.read_data2_r !== 16'h0 || bus.valid_r !== 1'b1) begin
        errors++; $display("FAIL midreset_regs R%0d/R%0d got %h/%h want 0/0",
                           i, i + 4, bus.read_data1_r, bus.read_data2_r);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic        iv;
    bit          hold;
    hold = 0;
    ins = 16'h0;
    iv = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        ins = 16'($urandom);
        if ($urandom_range(0, 2) == 0) ins[15:13] = 3'd3;
        iv = ($urandom_range(0, 7) != 0);
      end
      drive(ins, iv, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            1'($urandom), 3'($urandom), 16'($urandom));
      checks++;
      if (bus.hazard_stall !== exp_hstall()) begin
        errors++; $display("FAIL rand_hz n=%0d got %b want %b", n, bus.hazard_stall, exp_hstall());
      end
      hold = exp_hstall();
      tick();
      checks++;
      if ({actual(), bus.bubble_count, bus2.bubble_count} !== {m, 8'(m_cnt), 2'(m_cnt2)}) begin
        errors++;
        $display("FAIL rand_entry n=%0d got %h want %h", n,
                 {actual(), bus.bubble_count, bus2.bubble_count}, {m, 8'(m_cnt), 2'(m_cnt2)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_no_hazard();
    test_flush_hazard();
    test_stall();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
